// File: rtl/tdc_phase_dec.sv
`default_nettype none
// ============================================================================
// Module      : tdc_phase_dec
// Description : Ring-oscillator TDC phase decoder. Double-registers the raw
//               16-stage ring word, decodes the normalised thermometer code
//               into a 5-bit phase, and tracks phase advance, a running
//               phase accumulator and a saturating invalid-code counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_phase_dec #(
  parameter int ACC_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      ring_state,
  input  logic             sample_en,
  input  logic             clr,
  output logic [4:0]       phase,
  output logic             phase_vld,
  output logic [4:0]       dphase,
  output logic             dphase_vld,
  output logic [ACC_W-1:0] phase_acc,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  // Odd inverter stages are inverted; flipping them yields a thermometer code.
  localparam logic [15:0] ODD_MASK = 16'hAAAA;

  // Capture pipeline
  logic [15:0] s1_q, s1_d, s2_q, s2_d;
  logic        v1_q, v1_d, v2_q, v2_d;

  // Decode results
  logic [15:0] t_norm;
  logic        code_ok;
  logic [4:0]  code_phase;
  logic [4:0]  phase_step;

  // Result state
  logic [4:0]       phase_q, phase_d;
  logic             phase_vld_q, phase_vld_d;
  logic [4:0]       dphase_q, dphase_d;
  logic             dphase_vld_q, dphase_vld_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             has_prev_q, has_prev_d;

  // Capture stages always load; the valid bit follows the data word.
  always_comb begin
    s1_d = ring_state;
    v1_d = sample_en;
    s2_d = s1_q;
    v2_d = v1_q;
  end

  // Two-flop capture of the asynchronous ring word (second flop is the metastability guard).
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      v1_q <= 1'b0;
      s2_q <= '0;
      v2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      v1_q <= v1_d;
      s2_q <= s2_d;
      v2_q <= v2_d;
    end
  end

  // Match the normalised word against the 32 legal thermometer patterns; no bubble fixing.
  always_comb begin
    logic [15:0] thermo;
    t_norm     = s2_q ^ ODD_MASK;
    code_ok    = 1'b0;
    code_phase = 5'd0;
    thermo     = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      thermo = (16'h0001 << k) - 16'h0001;
      if (t_norm == thermo) begin
        code_ok    = 1'b1;
        code_phase = 5'(k);
      end
      if (t_norm == ~thermo) begin
        code_ok    = 1'b1;
        code_phase = 5'(k + 16);
      end
    end
  end

  // Next-state of the result registers; clr overrides accumulator and counter.
  always_comb begin
    phase_step   = code_phase - phase_q;
    phase_d      = phase_q;
    phase_vld_d  = 1'b0;
    dphase_d     = dphase_q;
    dphase_vld_d = 1'b0;
    acc_d        = acc_q;
    err_d        = 1'b0;
    err_cnt_d    = err_cnt_q;
    has_prev_d   = has_prev_q;

    if (v2_q) begin
      if (code_ok) begin
        phase_d     = code_phase;
        phase_vld_d = 1'b1;
        has_prev_d  = 1'b1;
        // A coinciding clr starts a fresh history, so no advance is reported.
        if (has_prev_q && !clr) begin
          dphase_d     = phase_step;
          dphase_vld_d = 1'b1;
          acc_d        = acc_q + ACC_W'(phase_step);
        end
      end else begin
        err_d = 1'b1;
        if (err_cnt_q != {ERR_W{1'b1}}) begin
          err_cnt_d = err_cnt_q + ERR_W'(1);
        end
      end
    end

    if (clr) begin
      acc_d     = '0;
      err_cnt_d = '0;
      // A valid phase landing with clr becomes the new reference.
      if (!(v2_q && code_ok)) begin
        has_prev_d = 1'b0;
      end
    end
  end

  // Registered result stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= '0;
      phase_vld_q  <= 1'b0;
      dphase_q     <= '0;
      dphase_vld_q <= 1'b0;
      acc_q        <= '0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
      has_prev_q   <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      phase_vld_q  <= phase_vld_d;
      dphase_q     <= dphase_d;
      dphase_vld_q <= dphase_vld_d;
      acc_q        <= acc_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
      has_prev_q   <= has_prev_d;
    end
  end

  assign phase      = phase_q;
  assign phase_vld  = phase_vld_q;
  assign dphase     = dphase_q;
  assign dphase_vld = dphase_vld_q;
  assign phase_acc  = acc_q;
  assign err        = err_q;
  assign err_cnt    = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tdc_phase_dec.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdc_phase_dec
// Description : Scoreboard bench for tdc_phase_dec. Each driven sample pushes
//               its expected result; the monitor pops on every strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdc_phase_dec;

  localparam int ACC_W = 8;
  localparam int ERR_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [15:0]      ring_state;
  logic             sample_en;
  logic             clr;
  logic [4:0]       phase;
  logic             phase_vld;
  logic [4:0]       dphase;
  logic             dphase_vld;
  logic [ACC_W-1:0] phase_acc;
  logic             err;
  logic [ERR_W-1:0] err_cnt;

  tdc_phase_dec #(.ACC_W(ACC_W), .ERR_W(ERR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ring_state (ring_state),
    .sample_en  (sample_en),
    .clr        (clr),
    .phase      (phase),
    .phase_vld  (phase_vld),
    .dphase     (dphase),
    .dphase_vld (dphase_vld),
    .phase_acc  (phase_acc),
    .err        (err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit is_err;
    int phase;
    bit dvld;
    int dphase;
    int acc;
    int ecnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected ring word for phase p, built straight from the code definition.
  function automatic logic [15:0] code_of(input int p);
    logic [15:0] one;
    logic [15:0] t;
    one = 16'h0001;
    if (p < 16) t = (one << p) - one;
    else        t = ~((one << (p - 16)) - one);
    return t ^ 16'hAAAA;
  endfunction

  function automatic int dec(input logic [15:0] w);
    for (int p = 0; p < 32; p++) if (code_of(p) == w) return p;
    return -1;
  endfunction

  // Reference model state
  int m_phase = 0, m_dphase = 0, m_acc = 0, m_cnt = 0;
  bit m_has = 0;
  bit cp0 = 0, cp1 = 0;

  // One cycle of stimulus; clr_req applies to this sample's result cycle.
  task automatic step(input logic [15:0] w, input bit en, input bit clr_req);
    exp_t e;
    int   p;
    clr        = cp1;
    cp1        = cp0;
    cp0        = clr_req;
    ring_state = w;
    sample_en  = en;
    e.cyc = cyc + 3;
    e.dvld = 0;
    e.is_err = 0;
    if (en) begin
      p = dec(w);
      if (p >= 0) begin
        if (m_has && !clr_req) begin
          m_dphase = (p - m_phase) & 31;
          m_acc    = (m_acc + m_dphase) % (1 << ACC_W);
          e.dvld   = 1;
        end
        m_phase = p;
        m_has   = 1;
      end else begin
        e.is_err = 1;
        if (m_cnt < (1 << ERR_W) - 1) m_cnt++;
      end
    end
    if (clr_req) begin
      m_acc = 0;
      m_cnt = 0;
      if (!(en && dec(w) >= 0)) m_has = 0;
    end
    if (en) begin
      e.phase  = m_phase;
      e.dphase = m_dphase;
      e.acc    = m_acc;
      e.ecnt   = m_cnt;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each strobe against the oldest expected result.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("missing_strobe", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (phase_vld === 1'b1 || err === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_strobe", {30'd0, phase_vld, err}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", cyc, e.cyc);
          chk("err", err, e.is_err);
          chk("phase_vld", phase_vld, !e.is_err);
          chk("phase", phase, e.phase);
          chk("dphase_vld", dphase_vld, e.dvld);
          chk("dphase", dphase, e.dphase);
          chk("phase_acc", phase_acc, e.acc);
          chk("err_cnt", err_cnt, e.ecnt);
        end
      end else if (dphase_vld === 1'b1) begin
        chk("lone_dphase_vld", dphase_vld, 1'b0);
      end
    end
  end

  initial begin
    logic [15:0] w;
    rst        = 1'b1;
    ring_state = 16'h0000;
    sample_en  = 1'b1;
    clr        = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_phase", phase, 0);
    chk("rst_dphase", dphase, 0);
    chk("rst_acc", phase_acc, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_strobes", {phase_vld, dphase_vld, err}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr = 1'b0;

    // Basic decode: p=3 then p=20
    step(16'hAAAD, 1, 0);
    step(16'h555A, 1, 0);
    repeat (3) step(16'h0000, 0, 0);
    // Phase wrap 30 -> 2
    step(16'h6AAA, 1, 0);
    step(16'hAAA9, 1, 0);
    // Single invalid word, then idle cycles with garbage on the ring
    step(16'h0000, 1, 0);
    repeat (4) step(16'($urandom), 0, 0);
    // clr coinciding with a valid p=5 result, then p=9
    step(code_of(5), 1, 1);
    step(code_of(9), 1, 0);
    // clr coinciding with an invalid result
    step(16'hFFFF, 1, 1);
    step(code_of(12), 1, 0);
    // clr with no sample in flight drops the history
    step(16'h0000, 0, 1);
    step(code_of(20), 1, 0);
    step(code_of(21), 1, 0);
    // Repeated +31 steps to wrap the 8-bit accumulator
    for (int k = 1; k <= 20; k++) step(code_of((21 + 31 * k) % 32), 1, 0);
    // All 32 valid codes
    for (int p = 0; p < 32; p++) step(code_of(p), 1, 0);
    // 1000 random invalid words, with some idle cycles mixed in
    for (int k = 0; k < 1000; k++) begin
      do w = 16'($urandom); while (dec(w) >= 0);
      step(w, 1, 0);
      if (k % 97 == 0) step(16'($urandom), 0, 0);
    end
    step(code_of(7), 1, 0);
    repeat (6) step(16'h0000, 0, 0);
    chk("drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
